rs_sched: RTL
=============

Name: rs_sched

Overview:
- Unified reservation station directly downstream of alloc.
- Buffers dispatched uops (t_disp_pkt) and tracks source readiness via writeback broadcasts.
- Selects the oldest ready uop each cycle into a registered issue slot for execute.
- Backpressures alloc with rs_stall_rs0 when no entry is free.

Parameters:
- NUM_RS_ENTRIES, 8, number of buffered uops; must be a power of 2, ≥2.
- NUM_WB_PORTS, 2, number of result-broadcast ports.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- nuke_rb1  in  t_nuke_pkt  flush request; only .valid is used
- disp_valid_rs0  in  1  dispatch valid; already gated by rs_stall_rs0 in alloc
- disp_pkt_rs0  in  t_disp_pkt  uop, robid, rename (psrc1/psrc2/pdst)
- disp_src_rdy_rs0  in  1 x NUM_SOURCES  per-source ready at dispatch; 1 for unused sources
- rs_stall_rs0  out  1  no free entry
- wb_valid_ex  in  1 x NUM_WB_PORTS  result broadcast valid
- wb_pdst_ex  in  t_prf_id x NUM_WB_PORTS  broadcast physical destination
- iss_ready_rs1  in  1  execute accepts the issue slot this cycle
- iss_valid_rs1  out  1  issue slot valid
- iss_pkt_rs1  out  t_disp_pkt  issued uop

Behaviour:
- Entry state: valid, pkt, src_rdy[NUM_SOURCES], age row (age matrix; age[i][j]=1 means i is older than j).
- Reset values: all entries invalid, age matrix 0, iss_valid_rs1=0, iss_pkt_rs1='0, rs_stall_rs0=0.
- Stall: rs_stall_rs0 = all entries valid. It is combinational from registered valid bits, so a full RS plus an issue in the same cycle still stalls; the freed entry is visible next cycle.
- Alloc (disp_valid_rs0 & ~nuke): write to the lowest-index free entry at the clock edge.
  - src_rdy[s] = disp_src_rdy_rs0[s] | any wb port matching psrc_s this cycle (same-cycle wakeup bypass).
  - Set age[new][*]=0 and age[*][new]=valid[*] (the new entry is youngest).
- Wakeup: each cycle, for every valid entry, set src_rdy[s] when any wb_valid_ex[p] & wb_pdst_ex[p]==psrc_s. Bits never clear.
- Eligible entry: valid & all src_rdy. Select is the eligible entry with no eligible older entry (oldest-first). Select is combinational over registered state, so wakeups landing this cycle are eligible next cycle.
- Issue slot is a one-deep register; it can load when ~iss_valid_rs1 | iss_ready_rs1.
  - On load: iss_pkt_rs1 ← selected pkt, iss_valid_rs1 ← 1, selected entry invalidated and its age column cleared, all at the same edge.
  - If the slot can load and nothing is eligible, iss_valid_rs1 ← 0.
  - iss_pkt_rs1 is held stable while iss_valid_rs1 & ~iss_ready_rs1.
- Latency: dispatch in cycle N with sources ready → earliest iss_valid_rs1 in N+2. Wakeup in N on a resident entry → earliest issue N+2.
- Simultaneous alloc + issue: the new entry cannot be selected in its write cycle. The allocated entry differs from the issued one because it takes a free index.
- Nuke (nuke_rb1.valid): at the next edge all entries and iss_valid_rs1 clear, and a dispatch in the same cycle is dropped. rs_stall_rs0 is 0 the cycle after.
- Reset mid-operation: identical to nuke plus iss_pkt_rs1 clears.
- Assertions (ASSERT): disp_valid_rs0 & rs_stall_rs0 never both high; at most one valid entry per robid; age matrix antisymmetric over valid entries.

Decomposition:
- common package: NUM_RS_ENTRIES default, t_rs_id (clog2 entries), t_prf_id if not already present, t_rs_entry struct (valid, pkt, src_rdy).
- Sub-module rs_age_matrix (NUM_ENTRIES): handles alloc/dealloc updates and the oldest-of-request-vector select. It is reusable for later load/store queues.
- Free-entry find-first stays inline.

Test Plan:
- Fill: 8 back-to-back dispatches with sources ready, iss_ready_rs1=0 → rs_stall_rs0=1 after the 8th write. The 9th is not accepted. The first issue presents the robid of dispatch #1.
- Ordering: dispatch robid 5, 6, 7, all ready, iss_ready_rs1=1 → issue 5, 6, 7 on consecutive cycles starting 2 cycles after robid 5 dispatched.
- Wakeup: robid 3 with psrc1=0x12 not ready, then robid 4 ready → 4 issues first. wb_pdst_ex=0x12 in cycle N → robid 3 issues in N+2.
- Bypass: dispatch psrc2=0x20 not ready in the same cycle as wb_pdst_ex[1]=0x20 → entry ready, issues 2 cycles later.
- Backpressure: iss_ready_rs1=0 for 4 cycles with iss_valid_rs1=1 → iss_pkt_rs1 is stable and entries are retained. When iss_ready_rs1 rises, the next-oldest uop is presented the following cycle.
- Nuke: 5 entries valid, issue slot full, nuke_rb1.valid plus a concurrent dispatch → next cycle iss_valid_rs1=0, rs_stall_rs0=0, no later issues from old uops.

Source files
------------

// File: rtl/rs_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rs_sched_pkg
// Description : Shared types for the unified reservation station: physical
//               register / ROB ids, dispatch and nuke packets, RS entry
//               record, and a helper that indexes a uop's sources.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package rs_sched_pkg;

  localparam int RS_ENTRIES_DEFAULT = 8;
  localparam int NUM_SOURCES        = 2;
  localparam int PRF_ID_W           = 7;
  localparam int ROB_ID_W           = 6;
  localparam int UOP_W              = 8;

  typedef logic [PRF_ID_W-1:0]                    t_prf_id;
  typedef logic [ROB_ID_W-1:0]                    t_rob_id;
  typedef logic [$clog2(RS_ENTRIES_DEFAULT)-1:0]  t_rs_id;

  typedef struct packed {
    logic [UOP_W-1:0] uop;
    t_rob_id          robid;
    t_prf_id          psrc1;
    t_prf_id          psrc2;
    t_prf_id          pdst;
  } t_disp_pkt;

  typedef struct packed {
    logic valid;
  } t_nuke_pkt;

  typedef struct packed {
    logic                   valid;
    t_disp_pkt              pkt;
    logic [NUM_SOURCES-1:0] src_rdy;
  } t_rs_entry;

  // Source s of a uop: 0 -> psrc1, 1 -> psrc2.
  function automatic t_prf_id disp_psrc(input t_disp_pkt p, input int unsigned s);
    return (s == 0) ? p.psrc1 : p.psrc2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rs_age_matrix.sv
`default_nettype none
// ============================================================================
// Module      : rs_age_matrix
// Description : Age matrix for an N-entry out-of-order buffer. age[i][j]=1
//               means entry i is older than entry j. Tracks allocation and
//               deallocation and picks the oldest requester.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               flush             - clear the whole matrix
//               valid_vec         - currently valid entries
//               alloc_valid/_id   - entry written this cycle (youngest)
//               dealloc_valid/_id - entry leaving this cycle
//               req_vec           - candidate entries
//               grant_vec         - one-hot oldest candidate (or zero)
// Revision    : 1.0 - initial release
// ============================================================================
module rs_age_matrix #(
  parameter int NUM_ENTRIES = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [NUM_ENTRIES-1:0]         valid_vec,
  input  logic                           alloc_valid,
  input  logic [$clog2(NUM_ENTRIES)-1:0] alloc_id,
  input  logic                           dealloc_valid,
  input  logic [$clog2(NUM_ENTRIES)-1:0] dealloc_id,
  input  logic [NUM_ENTRIES-1:0]         req_vec,
  output logic [NUM_ENTRIES-1:0]         grant_vec
);

  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] r_age;
  logic [NUM_ENTRIES-1:0]                  w_older_valid;

  // An entry leaving in the same cycle must not be recorded as older than
  // the newcomer, otherwise its stale row would look valid after reuse.
  always_comb begin
    w_older_valid = valid_vec;
    if (dealloc_valid) begin
      w_older_valid[dealloc_id] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_age <= '0;
    end else begin
      if (dealloc_valid) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
          r_age[i][dealloc_id] <= 1'b0;
        end
      end
      if (alloc_valid) begin
        for (int j = 0; j < NUM_ENTRIES; j++) begin
          r_age[alloc_id][j] <= 1'b0;
        end
        for (int i = 0; i < NUM_ENTRIES; i++) begin
          r_age[i][alloc_id] <= w_older_valid[i];
        end
      end
    end
  end

  // Grant i when no other requester is older than i.
  always_comb begin
    logic blocked;
    grant_vec = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        if (req_vec[j] && r_age[j][i]) begin
          blocked = 1'b1;
        end
      end
      grant_vec[i] = req_vec[i] & ~blocked;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        for (int j = i + 1; j < NUM_ENTRIES; j++) begin
          if (valid_vec[i] && valid_vec[j]) begin
            a_age_antisym: assert (r_age[i][j] != r_age[j][i]);
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rs_sched.sv
`default_nettype none
// ============================================================================
// Module      : rs_sched
// Description : Unified reservation station. Buffers dispatched uops, wakes
//               sources from writeback broadcasts and issues the oldest
//               ready uop through a one-deep registered issue slot.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               nuke_rb1          - flush (only .valid used)
//               disp_valid_rs0    - dispatch valid (alloc gates with stall)
//               disp_pkt_rs0      - dispatched uop
//               disp_src_rdy_rs0  - per-source ready at dispatch
//               rs_stall_rs0      - all entries occupied
//               wb_valid_ex       - per-port broadcast valid
//               wb_pdst_ex        - per-port broadcast destination
//               iss_ready_rs1     - execute takes the issue slot
//               iss_valid_rs1     - issue slot valid
//               iss_pkt_rs1       - issued uop
// Revision    : 1.0 - initial release
// ============================================================================
module rs_sched
  import rs_sched_pkg::*;
#(
  parameter int NUM_RS_ENTRIES = RS_ENTRIES_DEFAULT,
  parameter int NUM_WB_PORTS   = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  t_nuke_pkt                        nuke_rb1,
  input  logic                             disp_valid_rs0,
  input  t_disp_pkt                        disp_pkt_rs0,
  input  logic [NUM_SOURCES-1:0]           disp_src_rdy_rs0,
  output logic                             rs_stall_rs0,
  input  logic [NUM_WB_PORTS-1:0]          wb_valid_ex,
  input  t_prf_id [NUM_WB_PORTS-1:0]       wb_pdst_ex,
  input  logic                             iss_ready_rs1,
  output logic                             iss_valid_rs1,
  output t_disp_pkt                        iss_pkt_rs1
);

  localparam int ID_W = $clog2(NUM_RS_ENTRIES);

  t_rs_entry                                 r_ent [NUM_RS_ENTRIES];
  logic                                      r_iss_valid;
  t_disp_pkt                                 r_iss_pkt;

  logic [NUM_RS_ENTRIES-1:0]                 w_valid;
  logic [NUM_RS_ENTRIES-1:0]                 w_eligible;
  logic [NUM_RS_ENTRIES-1:0]                 w_grant;
  logic [NUM_RS_ENTRIES-1:0][NUM_SOURCES-1:0] w_wake;
  logic [NUM_SOURCES-1:0]                    w_disp_rdy;
  logic                                      w_nuke;
  logic                                      w_free_found;
  logic [ID_W-1:0]                           w_free_id;
  logic [ID_W-1:0]                           w_sel_id;
  t_disp_pkt                                 w_sel_pkt;
  logic                                      w_alloc;
  logic                                      w_load;
  logic                                      w_issue;

  assign w_nuke = nuke_rb1.valid;

  // Same-cycle bypass: a broadcast landing with the dispatch marks the
  // source ready as it is written.
  always_comb begin
    w_disp_rdy = disp_src_rdy_rs0;
    for (int s = 0; s < NUM_SOURCES; s++) begin
      for (int p = 0; p < NUM_WB_PORTS; p++) begin
        if (wb_valid_ex[p] && (wb_pdst_ex[p] == disp_psrc(disp_pkt_rs0, s))) begin
          w_disp_rdy[s] = 1'b1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RS_ENTRIES; gi++) begin : g_entry
    assign w_valid[gi]    = r_ent[gi].valid;
    assign w_eligible[gi] = r_ent[gi].valid & (&r_ent[gi].src_rdy);

    always_comb begin
      w_wake[gi] = '0;
      for (int s = 0; s < NUM_SOURCES; s++) begin
        for (int p = 0; p < NUM_WB_PORTS; p++) begin
          if (wb_valid_ex[p] && (wb_pdst_ex[p] == disp_psrc(r_ent[gi].pkt, s))) begin
            w_wake[gi][s] = 1'b1;
          end
        end
      end
    end
  end

  // Lowest-index free entry (scan downward so the lowest hit wins).
  always_comb begin
    w_free_found = 1'b0;
    w_free_id    = '0;
    for (int i = NUM_RS_ENTRIES - 1; i >= 0; i--) begin
      if (!w_valid[i]) begin
        w_free_found = 1'b1;
        w_free_id    = ID_W'(i);
      end
    end
  end

  always_comb begin
    w_sel_id  = '0;
    w_sel_pkt = '0;
    for (int i = 0; i < NUM_RS_ENTRIES; i++) begin
      if (w_grant[i]) begin
        w_sel_id  = ID_W'(i);
        w_sel_pkt = r_ent[i].pkt;
      end
    end
  end

  assign w_alloc = disp_valid_rs0 & ~w_nuke & w_free_found;
  assign w_load  = ~r_iss_valid | iss_ready_rs1;
  assign w_issue = w_load & (|w_eligible) & ~w_nuke;

  rs_age_matrix #(
    .NUM_ENTRIES   (NUM_RS_ENTRIES)
  ) u_age (
    .clk           (clk),
    .reset         (reset),
    .flush         (w_nuke),
    .valid_vec     (w_valid),
    .alloc_valid   (w_alloc),
    .alloc_id      (w_free_id),
    .dealloc_valid (w_issue),
    .dealloc_id    (w_sel_id),
    .req_vec       (w_eligible),
    .grant_vec     (w_grant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_RS_ENTRIES; i++) begin
        r_ent[i] <= '0;
      end
      r_iss_valid <= 1'b0;
      r_iss_pkt   <= '0;
    end else if (w_nuke) begin
      for (int i = 0; i < NUM_RS_ENTRIES; i++) begin
        r_ent[i].valid <= 1'b0;
      end
      r_iss_valid <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_RS_ENTRIES; i++) begin
        if (r_ent[i].valid) begin
          r_ent[i].src_rdy <= r_ent[i].src_rdy | w_wake[i];
        end
      end
      if (w_load) begin
        r_iss_valid <= w_issue;
        if (w_issue) begin
          r_iss_pkt                <= w_sel_pkt;
          r_ent[w_sel_id].valid    <= 1'b0;
        end
      end
      // The allocated index is free, so it never collides with the issued one.
      if (w_alloc) begin
        r_ent[w_free_id].valid   <= 1'b1;
        r_ent[w_free_id].pkt     <= disp_pkt_rs0;
        r_ent[w_free_id].src_rdy <= w_disp_rdy;
      end
    end
  end

  assign rs_stall_rs0  = &w_valid;
  assign iss_valid_rs1 = r_iss_valid;
  assign iss_pkt_rs1   = r_iss_pkt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_no_disp_on_stall: assert (!(disp_valid_rs0 && rs_stall_rs0));
      for (int i = 0; i < NUM_RS_ENTRIES; i++) begin
        for (int j = i + 1; j < NUM_RS_ENTRIES; j++) begin
          if (w_valid[i] && w_valid[j]) begin
            a_unique_robid: assert (r_ent[i].pkt.robid != r_ent[j].pkt.robid);
          end
        end
      end
    end
  end

endmodule
`default_nettype wire
